// File: rtl/axi4_lite_master_if.sv
// Bundle of system-side request/response signals and AXI4-Lite channels for axi4_lite_master.
// Port names are kept identical to the master's flat signal names so both sides read naturally.
interface axi4_lite_master_if #(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32,
  parameter int AXI_SW = AXI_DW >> 3
);
  logic [AXI_AW-1:0] sys_addr_i;
  logic [AXI_DW-1:0] sys_wdata_i;
  logic [AXI_SW-1:0] sys_sel_i;
  logic              sys_wen_i;
  logic              sys_ren_i;
  logic [AXI_DW-1:0] sys_rdata_o;
  logic              sys_ack_o;
  logic              sys_err_o;
  logic              sys_busy_o;

  logic [AXI_AW-1:0] axi_awaddr_o;
  logic [2:0]        axi_awprot_o;
  logic              axi_awvalid_o;
  logic              axi_awready_i;
  logic [AXI_DW-1:0] axi_wdata_o;
  logic [AXI_SW-1:0] axi_wstrb_o;
  logic              axi_wvalid_o;
  logic              axi_wready_i;
  logic [1:0]        axi_bresp_i;
  logic              axi_bvalid_i;
  logic              axi_bready_o;

  logic [AXI_AW-1:0] axi_araddr_o;
  logic [2:0]        axi_arprot_o;
  logic              axi_arvalid_o;
  logic              axi_arready_i;
  logic [AXI_DW-1:0] axi_rdata_i;
  logic [1:0]        axi_rresp_i;
  logic              axi_rvalid_i;
  logic              axi_rready_o;

  modport master (
    input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_ack_o, sys_err_o, sys_busy_o,
    output axi_awaddr_o, axi_awprot_o, axi_awvalid_o,
    input  axi_awready_i,
    output axi_wdata_o, axi_wstrb_o, axi_wvalid_o,
    input  axi_wready_i, axi_bresp_i, axi_bvalid_i,
    output axi_bready_o,
    output axi_araddr_o, axi_arprot_o, axi_arvalid_o,
    input  axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rvalid_i,
    output axi_rready_o
  );

  modport slave (
    output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_ack_o, sys_err_o, sys_busy_o,
    input  axi_awaddr_o, axi_awprot_o, axi_awvalid_o,
    output axi_awready_i,
    input  axi_wdata_o, axi_wstrb_o, axi_wvalid_o,
    output axi_wready_i, axi_bresp_i, axi_bvalid_i,
    input  axi_bready_o,
    input  axi_araddr_o, axi_arprot_o, axi_arvalid_o,
    output axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rvalid_i,
    input  axi_rready_o
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a simple strobe/ack system bus onto AXI.
// Optional response timeout with DRAIN recovery is enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32,
  parameter int AXI_SW = AXI_DW >> 3
) (
  input  logic                 axi_clk_i,
  input  logic                 axi_rstn_i,
  axi4_lite_master_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_e;

  state_e            state_q,   state_d;
  logic [AXI_AW-1:0] addr_q,    addr_d;
  logic [AXI_DW-1:0] wdata_q,   wdata_d;
  logic [AXI_SW-1:0] sel_q,     sel_d;
  logic [AXI_DW-1:0] rdata_q,   rdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q,  bready_d;
  logic              rready_q,  rready_d;
  logic              ack_q,     ack_d;
  logic              err_q,     err_d;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  logic [5:0]        cnt_q,     cnt_d;
  logic              is_wr_q,   is_wr_d;
`endif

  logic aw_left, w_left, ar_hs, b_hs, r_hs;

  // A channel is still "left" when its valid is up and this cycle brings no ready.
  assign aw_left = awvalid_q & ~bus.axi_awready_i;
  assign w_left  = wvalid_q  & ~bus.axi_wready_i;
  assign ar_hs   = arvalid_q &  bus.axi_arready_i;
  assign b_hs    = bready_q  &  bus.axi_bvalid_i;
  assign r_hs    = rready_q  &  bus.axi_rvalid_i;

  always_comb begin
    // NOTE: every _d starts from its _q (pulses from zero) so no path through the case infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sys_wen_i) begin
          addr_d    = bus.sys_addr_i;
          wdata_d   = bus.sys_wdata_i;
          sel_d     = bus.sys_sel_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (bus.sys_ren_i) begin
          addr_d    = bus.sys_addr_i;
          arvalid_d = 1'b1;
          state_d   = RD_REQ;
        end
      end
      WR_REQ: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = bus.axi_bresp_i inside {2'b10, 2'b11};
          state_d  = IDLE;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          rready_d = 1'b0;
          rdata_d  = bus.axi_rdata_i;
          ack_d    = 1'b1;
          err_d    = bus.axi_rresp_i inside {2'b10, 2'b11};
          state_d  = IDLE;
        end
      end
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      DRAIN: begin
        // The requester already got its error ack; finish the bus side silently.
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        arvalid_d = arvalid_q & ~bus.axi_arready_i;
        if (is_wr_q) begin
          if (b_hs) begin
            bready_d = 1'b0;
            state_d  = IDLE;
          end else if (!aw_left && !w_left) begin
            bready_d = 1'b1;
          end
        end else begin
          if (r_hs) begin
            rready_d = 1'b0;
            state_d  = IDLE;
          end else if (ar_hs) begin
            rready_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    if (state_q == IDLE) begin
      cnt_d   = 6'd1;
      is_wr_d = bus.sys_wen_i;
    end else if (state_q != DRAIN) begin
      cnt_d = cnt_q + 6'd1;
      // Cycle 31 after acceptance with no response this cycle: give up on the requester's behalf.
      if (state_d != IDLE && cnt_q == 6'd31) begin
        ack_d   = 1'b1;
        err_d   = 1'b1;
        state_d = DRAIN;
      end
    end
`endif
  end

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
`endif
    end
  end

  assign bus.axi_awaddr_o  = addr_q;
  assign bus.axi_awprot_o  = 3'b000;
  assign bus.axi_awvalid_o = awvalid_q;
  assign bus.axi_wdata_o   = wdata_q;
  assign bus.axi_wstrb_o   = sel_q;
  assign bus.axi_wvalid_o  = wvalid_q;
  assign bus.axi_bready_o  = bready_q;
  assign bus.axi_araddr_o  = addr_q;
  assign bus.axi_arprot_o  = 3'b000;
  assign bus.axi_arvalid_o = arvalid_q;
  assign bus.axi_rready_o  = rready_q;
  assign bus.sys_rdata_o   = rdata_q;
  assign bus.sys_ack_o     = ack_q;
  assign bus.sys_err_o     = err_q;
  assign bus.sys_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: configurable-latency AXI slave, transaction-level model
// checked every cycle, plus literal latency/data expectations for each scenario.
module tb_axi4_lite_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite_master_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW)) bus ();

  axi4_lite_master #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW)) dut (
    .axi_clk_i  (clk),
    .axi_rstn_i (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave with per-channel wait configuration ----------------
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic hold_resp = 1'b0;
  logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
  logic [31:0] rdata_c = 32'h0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic s_aw, s_w, s_ar, s_bvalid, s_rvalid;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign bus.axi_awready_i = bus.axi_awvalid_o && (aw_cnt >= aw_wait);
  assign bus.axi_wready_i  = bus.axi_wvalid_o  && (w_cnt  >= w_wait);
  assign bus.axi_arready_i = bus.axi_arvalid_o && (ar_cnt >= ar_wait);
  assign bus.axi_bvalid_i  = s_bvalid;
  assign bus.axi_bresp_i   = bresp_c;
  assign bus.axi_rvalid_i  = s_rvalid;
  assign bus.axi_rdata_i   = rdata_c;
  assign bus.axi_rresp_i   = rresp_c;

  assign aw_hs = bus.axi_awvalid_o && bus.axi_awready_i;
  assign w_hs  = bus.axi_wvalid_o  && bus.axi_wready_i;
  assign ar_hs = bus.axi_arvalid_o && bus.axi_arready_i;
  assign b_hs  = bus.axi_bready_o  && bus.axi_bvalid_i;
  assign r_hs  = bus.axi_rready_o  && bus.axi_rvalid_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (bus.axi_awvalid_o) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= 0; else if (bus.axi_wvalid_o)  w_cnt  <= w_cnt + 1;
      if (ar_hs) ar_cnt <= 0; else if (bus.axi_arvalid_o) ar_cnt <= ar_cnt + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_aw <= 1'b0; s_w <= 1'b0; s_ar <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; b_cnt <= 0; r_cnt <= 0;
    end else begin
      if (aw_hs) s_aw <= 1'b1;
      if (w_hs)  s_w  <= 1'b1;
      if (ar_hs) s_ar <= 1'b1;
      if (b_hs) begin
        s_bvalid <= 1'b0; s_aw <= 1'b0; s_w <= 1'b0; b_cnt <= 0;
      end else if (!s_bvalid && (s_aw || aw_hs) && (s_w || w_hs) && !hold_resp) begin
        if (b_cnt >= b_wait) s_bvalid <= 1'b1; else b_cnt <= b_cnt + 1;
      end
      if (r_hs) begin
        s_rvalid <= 1'b0; s_ar <= 1'b0; r_cnt <= 0;
      end else if (!s_rvalid && (s_ar || ar_hs) && !hold_resp) begin
        if (r_cnt >= r_wait) s_rvalid <= 1'b1; else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  logic        m_busy, m_wr, m_aw, m_w, m_ar, m_drain, m_ack, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_sel;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_wr <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_ar <= 1'b0;
      m_drain <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_sel <= '0; m_age <= 0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (!m_busy) begin
        if (bus.sys_wen_i || bus.sys_ren_i) begin
          m_busy <= 1'b1; m_wr <= bus.sys_wen_i; m_addr <= bus.sys_addr_i;
          m_wdata <= bus.sys_wdata_i; m_sel <= bus.sys_sel_i;
          m_aw <= 1'b0; m_w <= 1'b0; m_ar <= 1'b0; m_drain <= 1'b0; m_age <= 1;
        end
      end else begin
        m_age <= m_age + 1;
        if (aw_hs) m_aw <= 1'b1;
        if (w_hs)  m_w  <= 1'b1;
        if (ar_hs) m_ar <= 1'b1;
        if (b_hs || r_hs) begin
          m_busy <= 1'b0;
          if (!m_drain) begin
            m_ack <= 1'b1;
            m_err <= b_hs ? bresp_c[1] : rresp_c[1];
            if (r_hs) m_rdata <= rdata_c;
          end
        end else if (TIMEOUT && !m_drain && m_age == 31) begin
          m_ack <= 1'b1; m_err <= 1'b1; m_drain <= 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_aw, exp_w, exp_ar;
      exp_aw = m_busy && m_wr && !m_aw;
      exp_w  = m_busy && m_wr && !m_w;
      exp_ar = m_busy && !m_wr && !m_ar;
      check("busy",    64'(bus.sys_busy_o),    64'(m_busy));
      check("ack",     64'(bus.sys_ack_o),     64'(m_ack));
      if (m_ack) check("err", 64'(bus.sys_err_o), 64'(m_err));
      check("rdata",   64'(bus.sys_rdata_o),   64'(m_rdata));
      check("awvalid", 64'(bus.axi_awvalid_o), 64'(exp_aw));
      check("wvalid",  64'(bus.axi_wvalid_o),  64'(exp_w));
      check("arvalid", 64'(bus.axi_arvalid_o), 64'(exp_ar));
      check("bready",  64'(bus.axi_bready_o),  64'(m_busy && m_wr && m_aw && m_w));
      check("rready",  64'(bus.axi_rready_o),  64'(m_busy && !m_wr && m_ar));
      check("prot",    64'({bus.axi_awprot_o, bus.axi_arprot_o}), 64'd0);
      if (exp_aw) check("awaddr", 64'(bus.axi_awaddr_o), 64'(m_addr));
      if (exp_w) begin
        check("wdata", 64'(bus.axi_wdata_o), 64'(m_wdata));
        check("wstrb", 64'(bus.axi_wstrb_o), 64'(m_sel));
      end
      if (exp_ar) check("araddr", 64'(bus.axi_araddr_o), 64'(m_addr));
    end
  end

  // ---------------- monitors for literal expectations ----------------
  int cyc = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, ack_cnt = 0, ack_cyc = 0;
  logic        last_err;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_hs) last_awaddr <= bus.axi_awaddr_o;
    if (w_hs) begin last_wdata <= bus.axi_wdata_o; last_wstrb <= bus.axi_wstrb_o; end
    if (ar_hs) last_araddr <= bus.axi_araddr_o;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.axi_awvalid_o) aw_hi++;
      if (bus.axi_wvalid_o)  w_hi++;
      if (bus.axi_arvalid_o) ar_hi++;
      if (bus.sys_ack_o) begin ack_cnt++; ack_cyc = cyc; last_err = bus.sys_err_o; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, output int n);
    @(posedge clk); #1;
    bus.sys_wen_i = wen; bus.sys_ren_i = ren;
    bus.sys_addr_i = addr; bus.sys_wdata_i = data; bus.sys_sel_i = sel;
    n = cyc;
    @(posedge clk); #1;
    bus.sys_wen_i = 1'b0; bus.sys_ren_i = 1'b0;
  endtask

  task automatic wait_ack(input int base, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (ack_cnt > base) seen = 1'b1;
    end
    if (!seen) check(name, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (!bus.sys_busy_o) seen = 1'b1;
    end
    if (!seen) check(name, 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.sys_busy_o),  64'd0);
    check({tag, "_ack"},   64'(bus.sys_ack_o),   64'd0);
    check({tag, "_err"},   64'(bus.sys_err_o),   64'd0);
    check({tag, "_rdata"}, 64'(bus.sys_rdata_o), 64'd0);
    check({tag, "_valids"}, 64'({bus.axi_awvalid_o, bus.axi_wvalid_o, bus.axi_arvalid_o}), 64'd0);
    check({tag, "_readies"}, 64'({bus.axi_bready_o, bus.axi_rready_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b_ack, b_aw, b_w, b_ar;
    bus.sys_wen_i = 1'b0; bus.sys_ren_i = 1'b0;
    bus.sys_addr_i = '0; bus.sys_wdata_i = '0; bus.sys_sel_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait write: ack three cycles after the strobe
    b_ack = ack_cnt;
    strobe(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'hF, n);
    wait_ack(b_ack, 20, "wr0_timeout");
    check("wr0_latency", 64'(ack_cyc - n), 64'd3);
    check("wr0_err",     64'(last_err), 64'd0);
    check("wr0_awaddr",  64'(last_awaddr), 64'h40);
    check("wr0_wdata",   64'(last_wdata), 64'hDEAD_BEEF);
    check("wr0_wstrb",   64'(last_wstrb), 64'hF);

    // Read with arready delayed 3 cycles, SLVERR response
    ar_wait = 3; rdata_c = 32'h1234_5678; rresp_c = 2'b10;
    b_ack = ack_cnt; b_ar = ar_hi;
    strobe(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, n);
    wait_ack(b_ack, 20, "rd0_timeout");
    check("rd0_arvalid_cycles", 64'(ar_hi - b_ar), 64'd4);
    check("rd0_latency", 64'(ack_cyc - n), 64'd6);
    check("rd0_err",     64'(last_err), 64'd1);
    check("rd0_araddr",  64'(last_araddr), 64'h80);
    @(negedge clk);
    check("rd0_rdata_held", 64'(bus.sys_rdata_o), 64'h1234_5678);

    // W completes two cycles before AW
    ar_wait = 0; aw_wait = 2; rresp_c = 2'b00;
    b_ack = ack_cnt; b_aw = aw_hi; b_w = w_hi;
    strobe(1'b1, 1'b0, 32'h44, 32'h0000_00A5, 4'h1, n);
    wait_ack(b_ack, 20, "wr1_timeout");
    check("wr1_latency", 64'(ack_cyc - n), 64'd5);
    check("wr1_aw_cycles", 64'(aw_hi - b_aw), 64'd3);
    check("wr1_w_cycles",  64'(w_hi - b_w), 64'd1);
    repeat (5) @(posedge clk);
    check("wr1_single_ack", 64'(ack_cnt - b_ack), 64'd1);

    // Simultaneous wen/ren, then a read strobe while the write waits for B
    aw_wait = 0; b_wait = 3;
    b_ack = ack_cnt; b_ar = ar_hi;
    strobe(1'b1, 1'b1, 32'h48, 32'h1122_3344, 4'hC, n);
    @(posedge clk); #1;
    bus.sys_ren_i = 1'b1; bus.sys_addr_i = 32'h90;
    @(posedge clk); #1;
    bus.sys_ren_i = 1'b0;
    wait_ack(b_ack, 20, "wr2_timeout");
    check("wr2_latency", 64'(ack_cyc - n), 64'd6);
    repeat (5) @(posedge clk);
    #1;
    check("wr2_no_ar",      64'(ar_hi - b_ar), 64'd0);
    check("wr2_single_ack", 64'(ack_cnt - b_ack), 64'd1);
    check("wr2_awaddr",     64'(last_awaddr), 64'h48);
    check("wr2_wstrb",      64'(last_wstrb), 64'hC);
    b_wait = 0;

    // Reset asserted while waiting for R
    r_wait = 5; rdata_c = 32'hA5A5_A5A5;
    strobe(1'b0, 1'b1, 32'h84, 32'h0, 4'h0, n);
    @(posedge clk);
    @(posedge clk); #3;
    check("rd1_in_resp", 64'({bus.sys_busy_o, bus.axi_rready_o}), 64'b11);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    r_wait = 0; rdata_c = 32'hCAFE_F00D; rresp_c = 2'b00;
    b_ack = ack_cnt;
    strobe(1'b0, 1'b1, 32'h88, 32'h0, 4'h0, n);
    wait_ack(b_ack, 20, "rd2_timeout");
    check("rd2_latency", 64'(ack_cyc - n), 64'd3);
    check("rd2_err",     64'(last_err), 64'd0);
    @(negedge clk);
    check("rd2_rdata",   64'(bus.sys_rdata_o), 64'hCAFE_F00D);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // Slave withholds B: error ack at acceptance+32, late B drained without a second ack
    hold_resp = 1'b1; bresp_c = 2'b00;
    b_ack = ack_cnt;
    strobe(1'b1, 1'b0, 32'h4C, 32'h0BAD_F00D, 4'hF, n);
    wait_ack(b_ack, 60, "to_timeout");
    check("to_latency", 64'(ack_cyc - n), 64'd32);
    check("to_err",     64'(last_err), 64'd1);
    check("to_busy",    64'(bus.sys_busy_o), 64'd1);
    repeat (3) @(posedge clk);
    #1 hold_resp = 1'b0;
    wait_idle(20, "to_drain_timeout");
    repeat (5) @(posedge clk);
    #1;
    check("to_single_ack", 64'(ack_cnt - b_ack), 64'd1);
    check("to_rdata_kept", 64'(bus.sys_rdata_o), 64'hCAFE_F00D);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter AXI_DW, default 32: data width in bits (8,16,...,1024).
REQ-002 SHALL have parameter AXI_AW, default 32: address width in bits.
REQ-003 SHALL have parameter AXI_SW, default AXI_DW>>3: strobe width, one bit per data byte.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: axi_clk_i  in  1  AXI global clock; axi_rstn_i  in  1  AXI global reset.
REQ-005 SHALL have system-side ports: sys_addr_i in AXI_AW; sys_wdata_i in AXI_DW; sys_sel_i in AXI_SW (byte select); sys_wen_i in 1 (write strobe); sys_ren_i in 1 (read strobe); sys_rdata_o out AXI_DW; sys_ack_o out 1; sys_err_o out 1; sys_busy_o out 1 (transaction outstanding).
REQ-006 SHALL have AXI write ports: axi_awaddr_o out AXI_AW; axi_awprot_o out 3; axi_awvalid_o out 1; axi_awready_i in 1; axi_wdata_o out AXI_DW; axi_wstrb_o out AXI_SW; axi_wvalid_o out 1; axi_wready_i in 1; axi_bresp_i in 2; axi_bvalid_i in 1; axi_bready_o out 1.
REQ-007 SHALL have AXI read ports: axi_araddr_o out AXI_AW; axi_arprot_o out 3; axi_arvalid_o out 1; axi_arready_i in 1; axi_rdata_i in AXI_DW; axi_rresp_i in 2; axi_rvalid_i in 1; axi_rready_o out 1.

Function
REQ-008 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DRAIN; only one transaction outstanding.
REQ-009 In IDLE, sys_wen_i=1 SHALL latch address, wdata, sel and enter WR_REQ; sys_ren_i=1 (and sys_wen_i=0) SHALL latch address and enter RD_REQ.
REQ-010 Simultaneous sys_wen_i and sys_ren_i SHALL perform the write only; the read is dropped.
REQ-011 Strobes outside IDLE SHALL be ignored: no latch, no AXI activity, no ack.
REQ-012 axi_awvalid_o/axi_wvalid_o SHALL rise the cycle after acceptance; each SHALL stay high until its own handshake, independently, in either order or the same cycle.
REQ-013 WR_REQ SHALL go to WR_RESP once both AW and W have handshaken; axi_bready_o SHALL be high only in WR_RESP and DRAIN.
REQ-014 axi_arvalid_o SHALL rise the cycle after read acceptance and hold until arready; then RD_RESP with axi_rready_o=1.
REQ-015 On B or R handshake, next cycle SHALL give one-cycle sys_ack_o=1, sys_err_o=resp[1], return to IDLE; for reads sys_rdata_o=rdata registered at handshake, held until next read completes.
REQ-016 AXI address, data and strobe outputs SHALL be stable while corresponding valid is high; axi_awprot_o=axi_arprot_o=3'b000 always.
REQ-017 sys_busy_o SHALL be 1 in every state except IDLE; ack cycle is in IDLE.
REQ-018 Best-case write with zero-wait slave: strobe cycle N, AW/W handshake N+1, B handshake N+2, sys_ack_o N+3.

Reset
REQ-019 Asserting axi_rstn_i low SHALL immediately force IDLE and all outputs low/zero (valids, readies, sys_ack_o, sys_err_o, sys_busy_o, sys_rdata_o), including mid-transaction.
REQ-020 After reset release first accepted strobe SHALL be one sampled on or after first rising edge with axi_rstn_i high.

Configuration
REQ-021 Macro AXI4_LITE_MASTER_TIMEOUT_EN: when defined, a 6-bit counter SHALL start at acceptance; if no B/R handshake within 32 cycles, SHALL pulse sys_ack_o=1 with sys_err_o=1 and enter DRAIN.
REQ-022 In DRAIN pending valids SHALL be held to handshake and response accepted, then IDLE without further sys_ack_o; sys_rdata_o unchanged.
REQ-023 Without the macro, no counter or DRAIN state SHALL exist; the block waits indefinitely for the response.

Verification
REQ-024 Write 0x40=0xDEADBEEF, sel=0xF, zero-wait slave, bresp=00 -> awaddr 0x40, wstrb 0xF, sys_ack_o at N+3, sys_err_o=0.
REQ-025 Read 0x80, arready delayed 3 cycles, rdata=0x12345678, rresp=10 -> arvalid held 4 cycles, sys_rdata_o=0x12345678, sys_err_o=1.
REQ-026 wready 2 cycles before awready -> wvalid drops after its handshake, awvalid holds; one ack only after B.
REQ-027 sys_wen_i and sys_ren_i together, then sys_ren_i during WR_RESP -> single write, no AR activity.
REQ-028 Reset low during RD_RESP -> all outputs 0 immediately; next read completes normally.
REQ-029 With macro, slave never responds -> ack+err 32 cycles after acceptance; late bvalid drained, no extra ack.
